// File: rtl/vram_dma_multich_if.sv
// Bus-side bundle of the VRAM DMA: CPU bus handshake, source-RAM read port
// and destination write port. The DMA engine is the master.
interface vram_dma_multich_if #(
   parameter int AW = 14,
   parameter int DW = 16
);
   logic          BUSREQ;
   logic          BUSACK;
   logic          SRC_CS;
   logic [AW-1:0] SRC_ADDR;
   logic [DW-1:0] SRC_DATA;
   logic          WR_EN;
   logic [AW-1:0] WR_ADDR;
   logic [DW-1:0] WR_DATA;
   logic [2:0]    WR_CH;

   modport master (
      output BUSREQ, SRC_CS, SRC_ADDR, WR_EN, WR_ADDR, WR_DATA, WR_CH,
      input  BUSACK, SRC_DATA
   );

   modport slave (
      input  BUSREQ, SRC_CS, SRC_ADDR, WR_EN, WR_ADDR, WR_DATA, WR_CH,
      output BUSACK, SRC_DATA
   );
endinterface

// File: rtl/vram_dma_multich.sv
// Multi-channel word-copy DMA from source RAM to VRAM, one channel at a time,
// fixed-priority arbitration and CPU bus request/grant per transfer.
module vram_dma_multich_trig (
   input  logic CLK96,
   input  logic RESET96,
   input  logic trig,
   input  logic clr,
   output logic pend
);
   logic prev;

   // prev resets high so a TRIG held through reset is not seen as an edge
   always_ff @(posedge CLK96 or posedge RESET96) begin
      if (RESET96) begin
         prev <= 1'b1;
         pend <= 1'b0;
      end else begin
         prev <= trig;
         pend <= (pend | (trig & ~prev)) & ~clr;
      end
   end
endmodule

module vram_dma_multich #(
   parameter int NCH    = 4,
   parameter int AW     = 14,
   parameter int DW     = 16,
   parameter int LW     = 14,
   parameter int RD_LAT = 2
) (
   input  logic                  CLK96,
   input  logic                  RESET96,
   input  logic [NCH-1:0]        TRIG,
   input  logic [NCH*AW-1:0]     CH_SRC,
   input  logic [NCH*AW-1:0]     CH_DST,
   input  logic [NCH*LW-1:0]     CH_LEN,
   vram_dma_multich_if.master    bus,
   output logic                  BUSY,
   output logic [NCH-1:0]        DONE
);
   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_READ, S_WAIT, S_WRITE, S_REL
   } state_t;

   state_t         state, state_n;
   logic [NCH-1:0] pend, clr;
   logic [2:0]     gnt_ch, ch_q;
   logic           any_pend, ld;
   logic [AW-1:0]  src_q, dst_q;
   logic [LW-1:0]  len_q, idx_q, idx_nx;
   logic [2:0]     wcnt;
   logic [DW-1:0]  data_q;

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      vram_dma_multich_trig u_trig (
         .CLK96   (CLK96),
         .RESET96 (RESET96),
         .trig    (TRIG[g]),
         .clr     (clr[g]),
         .pend    (pend[g])
      );
   end

   // lowest pending index wins; scanning downward leaves the lowest one last
   always_comb begin
      gnt_ch = 3'd0;
      for (int i = NCH - 1; i >= 0; i--)
         if (pend[i]) gnt_ch = 3'(i);
   end

   assign any_pend = |pend;
   assign idx_nx   = idx_q + 1'b1;

   always_ff @(posedge CLK96 or posedge RESET96) begin
      if (RESET96) state <= S_IDLE;
      else         state <= state_n;
   end

   always_comb begin
      state_n = state;
      ld      = 1'b0;
      clr     = '0;
      case (state)
         S_IDLE:
            if (any_pend) begin
               state_n = S_REQ;
               ld      = 1'b1;
               clr     = NCH'(1) << gnt_ch;
            end
         S_REQ:
            if (bus.BUSACK) state_n = (len_q == '0) ? S_REL : S_READ;
         S_READ:  state_n = S_WAIT;
         S_WAIT:
            if (wcnt == 3'(RD_LAT)) state_n = S_WRITE;
         S_WRITE:
            // a lost grant parks in REQ with idx kept, so the copy resumes in place
            if (idx_nx == len_q)  state_n = S_REL;
            else if (bus.BUSACK)  state_n = S_READ;
            else                  state_n = S_REQ;
         S_REL:   state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK96 or posedge RESET96) begin
      if (RESET96) begin
         ch_q   <= 3'd0;
         src_q  <= '0;
         dst_q  <= '0;
         len_q  <= '0;
         idx_q  <= '0;
         wcnt   <= 3'd0;
         data_q <= '0;
      end else begin
         if (ld) begin
            ch_q  <= gnt_ch;
            src_q <= CH_SRC[gnt_ch*AW +: AW];
            dst_q <= CH_DST[gnt_ch*AW +: AW];
            len_q <= CH_LEN[gnt_ch*LW +: LW];
            idx_q <= '0;
         end
         // wcnt counts cycles since READ; data is valid on the RD_LAT-th
         if (state == S_READ) begin
            wcnt <= 3'd1;
         end else if (state == S_WAIT) begin
            wcnt <= wcnt + 3'd1;
            if (wcnt == 3'(RD_LAT)) data_q <= bus.SRC_DATA;
         end
         if (state == S_WRITE) idx_q <= idx_nx;
      end
   end

   assign bus.BUSREQ   = (state == S_REQ) || (state == S_READ) ||
                         (state == S_WAIT) || (state == S_WRITE);
   assign bus.SRC_CS   = (state == S_READ);
   assign bus.SRC_ADDR = bus.SRC_CS ? src_q + AW'(idx_q) : '0;
   assign bus.WR_EN    = (state == S_WRITE);
   assign bus.WR_ADDR  = bus.WR_EN ? dst_q + AW'(idx_q) : '0;
   assign bus.WR_DATA  = bus.WR_EN ? data_q : '0;
   assign bus.WR_CH    = ch_q;

   assign DONE = (state == S_REL) ? (NCH'(1) << ch_q) : '0;
   assign BUSY = any_pend || (state != S_IDLE);
endmodule

// File: tb/tb_vram_dma_multich.sv
// Directed bench for vram_dma_multich: source RAM model with RD_LAT latency,
// write/read/DONE logging monitor and hand-computed expectations.
module tb_vram_dma_multich;
   localparam int NCH = 4, AW = 14, DW = 16, LW = 14, RD_LAT = 2;

   logic              CLK96 = 1'b0;
   logic              RESET96 = 1'b1;
   logic [NCH-1:0]    TRIG = '0;
   logic [NCH*AW-1:0] CH_SRC = '0, CH_DST = '0;
   logic [NCH*LW-1:0] CH_LEN = '0;
   logic              BUSY;
   logic [NCH-1:0]    DONE;

   vram_dma_multich_if #(.AW(AW), .DW(DW)) bus ();

   vram_dma_multich #(.NCH(NCH), .AW(AW), .DW(DW), .LW(LW), .RD_LAT(RD_LAT)) dut (
      .CLK96   (CLK96),
      .RESET96 (RESET96),
      .TRIG    (TRIG),
      .CH_SRC  (CH_SRC),
      .CH_DST  (CH_DST),
      .CH_LEN  (CH_LEN),
      .bus     (bus),
      .BUSY    (BUSY),
      .DONE    (DONE)
   );

   always #5 CLK96 = ~CLK96;

   function automatic logic [DW-1:0] sdat(input logic [AW-1:0] a);
      return {2'b10, a} ^ 16'h0F0F;
   endfunction

   // source RAM: address captured each edge, data appears RD_LAT cycles after READ
   logic [AW-1:0] rd_pipe [RD_LAT] = '{default: '0};
   always @(posedge CLK96) begin
      rd_pipe[0] <= bus.SRC_ADDR;
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign bus.SRC_DATA = sdat(rd_pipe[RD_LAT-1]);

   int cyc = 0;
   always @(posedge CLK96) cyc <= cyc + 1;

   logic [AW-1:0] wa_q[$], ra_q[$];
   logic [DW-1:0] wd_q[$];
   int            wc_q[$], wt_q[$], do_q[$];
   int            done_cnt [NCH];
   int            cs_noack = 0, io_noreq = 0, req_rise = 0;
   logic          req_prev = 1'b0;

   always @(negedge CLK96) begin
      if (bus.WR_EN) begin
         wa_q.push_back(bus.WR_ADDR);
         wd_q.push_back(bus.WR_DATA);
         wc_q.push_back(int'(bus.WR_CH));
         wt_q.push_back(cyc);
      end
      if (bus.SRC_CS) ra_q.push_back(bus.SRC_ADDR);
      if (bus.SRC_CS && !bus.BUSACK) cs_noack++;
      if ((bus.SRC_CS || bus.WR_EN) && !bus.BUSREQ) io_noreq++;
      if (bus.BUSREQ && !req_prev) req_rise++;
      req_prev = bus.BUSREQ;
      for (int c = 0; c < NCH; c++)
         if (DONE[c]) begin
            done_cnt[c]++;
            do_q.push_back(c);
         end
   end

   int errs = 0, nchk = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge CLK96);
      #1;
   endtask

   task automatic clr_log();
      wa_q.delete(); wd_q.delete(); wc_q.delete(); wt_q.delete();
      ra_q.delete(); do_q.delete();
      foreach (done_cnt[c]) done_cnt[c] = 0;
      req_rise = 0;
   endtask

   task automatic set_ch(input int ch, input logic [AW-1:0] s, input logic [AW-1:0] d,
                         input logic [LW-1:0] l);
      CH_SRC[ch*AW +: AW] = s;
      CH_DST[ch*AW +: AW] = d;
      CH_LEN[ch*LW +: LW] = l;
   endtask

   task automatic trig_pulse(input logic [NCH-1:0] m);
      TRIG = TRIG | m;
      tick();
      TRIG = TRIG & ~m;
   endtask

   task automatic wait_done(input int ch, input int lim, input string tag);
      int k = 0;
      while (done_cnt[ch] == 0 && k < lim) begin
         tick();
         k++;
      end
      chk(tag, k < lim, 1'b1);
      tick(2);
   endtask

   task automatic chk_idle_outs(input string tag);
      chk({tag, "_busreq"}, bus.BUSREQ, 1'b0);
      chk({tag, "_srccs"},  bus.SRC_CS, 1'b0);
      chk({tag, "_wren"},   bus.WR_EN, 1'b0);
      chk({tag, "_busy"},   BUSY, 1'b0);
      chk({tag, "_done"},   DONE, '0);
      chk({tag, "_srcaddr"}, bus.SRC_ADDR, '0);
      chk({tag, "_wraddr"}, bus.WR_ADDR, '0);
      chk({tag, "_wrdata"}, bus.WR_DATA, '0);
      chk({tag, "_wrch"},   bus.WR_CH, '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   logic [AW-1:0] ea[4];
   logic [DW-1:0] ed[4];
   int            ec[4];
   logic [AW-1:0] er[4];

   initial begin
      bus.BUSACK = 1'b1;
      foreach (done_cnt[c]) done_cnt[c] = 0;
      RESET96 = 1'b1;
      tick(3);
      chk_idle_outs("rst");
      RESET96 = 1'b0;
      tick(2);

      // basic 4-word copy, ch0
      set_ch(0, 14'h0000, 14'h1000, 4);
      clr_log();
      trig_pulse(4'b0001);
      wait_done(0, 100, "s1_timeout");
      ea = '{14'h1000, 14'h1001, 14'h1002, 14'h1003};
      ed = '{16'h8F0F, 16'h8F0E, 16'h8F0D, 16'h8F0C};
      chk("s1_nwr", wa_q.size(), 4);
      for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
         chk($sformatf("s1_addr%0d", i), wa_q[i], ea[i]);
         chk($sformatf("s1_data%0d", i), wd_q[i], ed[i]);
         chk($sformatf("s1_ch%0d", i), wc_q[i], 0);
         if (i > 0) chk($sformatf("s1_gap%0d", i), wt_q[i] - wt_q[i-1], 4);
      end
      chk("s1_done", done_cnt[0], 1);
      chk("s1_busy", BUSY, 1'b0);

      // simultaneous trigger: ch1 before ch2, bus released in between
      set_ch(1, 14'h0100, 14'h2000, 2);
      set_ch(2, 14'h0200, 14'h2100, 2);
      clr_log();
      trig_pulse(4'b0110);
      wait_done(2, 200, "s2_timeout");
      ea = '{14'h2000, 14'h2001, 14'h2100, 14'h2101};
      ed = '{16'h8E0F, 16'h8E0E, 16'h8D0F, 16'h8D0E};
      ec = '{1, 1, 2, 2};
      chk("s2_nwr", wa_q.size(), 4);
      for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
         chk($sformatf("s2_addr%0d", i), wa_q[i], ea[i]);
         chk($sformatf("s2_data%0d", i), wd_q[i], ed[i]);
         chk($sformatf("s2_ch%0d", i), wc_q[i], ec[i]);
      end
      chk("s2_ndone", do_q.size(), 2);
      if (do_q.size() == 2) begin
         chk("s2_done_first", do_q[0], 1);
         chk("s2_done_second", do_q[1], 2);
      end
      chk("s2_busreq_rises", req_rise, 2);

      // grant dropped after first WRITE for 5 cycles
      set_ch(3, 14'h0300, 14'h3000, 3);
      clr_log();
      trig_pulse(4'b1000);
      begin
         int k = 0;
         int low = 0;
         while (!bus.WR_EN && k < 50) begin
            tick();
            k++;
         end
         chk("s3_first_wr_timeout", k < 50, 1'b1);
         bus.BUSACK = 1'b0;
         repeat (5) begin
            tick();
            if (!bus.BUSREQ) low++;
         end
         chk("s3_busreq_held", low, 0);
         chk("s3_reads_during_drop", ra_q.size(), 1);
         bus.BUSACK = 1'b1;
      end
      wait_done(3, 100, "s3_timeout");
      er = '{14'h0300, 14'h0301, 14'h0302, 14'h0000};
      ed = '{16'h8C0F, 16'h8C0E, 16'h8C0D, 16'h0000};
      chk("s3_nrd", ra_q.size(), 3);
      chk("s3_nwr", wa_q.size(), 3);
      for (int i = 0; i < 3 && i < ra_q.size(); i++)
         chk($sformatf("s3_rd%0d", i), ra_q[i], er[i]);
      for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
         chk($sformatf("s3_addr%0d", i), wa_q[i], 14'h3000 + 14'(i));
         chk($sformatf("s3_data%0d", i), wd_q[i], ed[i]);
      end
      chk("s3_cs_noack", cs_noack, 0);

      // empty transfer waits for grant, no accesses, DONE still pulses
      set_ch(0, 14'h0000, 14'h1000, 0);
      bus.BUSACK = 1'b0;
      clr_log();
      trig_pulse(4'b0001);
      tick(6);
      chk("s4_busreq_wait", bus.BUSREQ, 1'b1);
      chk("s4_busy_wait", BUSY, 1'b1);
      chk("s4_no_early_done", done_cnt[0], 0);
      bus.BUSACK = 1'b1;
      wait_done(0, 20, "s4_timeout");
      chk("s4_nwr", wa_q.size(), 0);
      chk("s4_nrd", ra_q.size(), 0);
      chk("s4_done", done_cnt[0], 1);
      chk("s4_busreq_off", bus.BUSREQ, 1'b0);

      // source address wraps at 2^AW
      set_ch(0, 14'h3FFE, 14'h0010, 4);
      clr_log();
      trig_pulse(4'b0001);
      wait_done(0, 100, "s5_timeout");
      er = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
      ed = '{16'hB0F1, 16'hB0F0, 16'h8F0F, 16'h8F0E};
      chk("s5_nrd", ra_q.size(), 4);
      for (int i = 0; i < 4 && i < ra_q.size(); i++)
         chk($sformatf("s5_rd%0d", i), ra_q[i], er[i]);
      for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
         chk($sformatf("s5_addr%0d", i), wa_q[i], 14'h0010 + 14'(i));
         chk($sformatf("s5_data%0d", i), wd_q[i], ed[i]);
      end

      // reset during WAIT of second word, TRIG held high across reset
      set_ch(1, 14'h0500, 14'h0600, 4);
      clr_log();
      TRIG[1] = 1'b1;
      begin
         int k = 0;
         while (ra_q.size() < 2 && k < 60) begin
            tick();
            k++;
         end
         chk("s6_second_read_timeout", k < 60, 1'b1);
      end
      chk("s6_wrch_before", bus.WR_CH, 3'd1);
      RESET96 = 1'b1;
      #1;
      chk_idle_outs("s6_rst");
      tick(2);
      req_rise = 0;
      RESET96 = 1'b0;
      tick(30);
      chk("s6_nwr", wa_q.size(), 1);
      chk("s6_no_done", done_cnt[1], 0);
      chk("s6_no_restart", req_rise, 0);
      chk("s6_busy", BUSY, 1'b0);
      TRIG = '0;
      tick(2);

      chk("io_without_busreq", io_noreq, 0);
      chk("srccs_without_busack", cs_noack, 0);

      $display("Result: errors=%0d of %0d checks", errs, nchk);
      $finish;
   end
endmodule

// File: doc/vram_dma_multich.md
VRAM_DMA_MULTICH -- requirements
Module: vram_dma_multich

Interface
REQ-001 SHALL have parameter NCH, default 4, number of DMA channels (1..8).
REQ-002 SHALL have parameter AW, default 14, word-address width.
REQ-003 SHALL have parameter DW, default 16, data width.
REQ-004 SHALL have parameter LW, default 14, transfer-length width in words.
REQ-005 SHALL have parameter RD_LAT, default 2, source-read latency in cycles (1..4).
REQ-006 SHALL have CLK96  in  1  system clock; all logic on its rising edge.
REQ-007 SHALL have RESET96  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have TRIG  in  NCH  per-channel start request, rising-edge sensitive.
REQ-009 SHALL have CH_SRC  in  NCH*AW  per-channel source base address, packed, channel 0 in LSBs.
REQ-010 SHALL have CH_DST  in  NCH*AW  per-channel destination base address, packed.
REQ-011 SHALL have CH_LEN  in  NCH*LW  per-channel length in words, packed; 0 = empty transfer.
REQ-012 SHALL have BUSREQ  out  1  bus request to CPU; BUSACK  in  1  bus grant.
REQ-013 SHALL have SRC_CS  out  1, SRC_ADDR  out  AW, SRC_DATA  in  DW: source-RAM read port.
REQ-014 SHALL have WR_EN  out  1, WR_ADDR  out  AW, WR_DATA  out  DW, WR_CH  out  3: destination write strobe, address, data, channel id.
REQ-015 SHALL have BUSY  out  1 (any channel pending or active) and DONE  out  NCH (one-cycle completion pulse per channel).

Function
REQ-016 SHALL latch a pending bit per channel on a TRIG 0->1 edge; a repeat edge on an already-pending channel SHALL have no effect.
REQ-017 SHALL, on a TRIG edge for the currently active channel, set its pending bit so the channel runs again after the current transfer.
REQ-018 SHALL arbitrate pending channels with fixed priority, lowest index first, and only in IDLE.
REQ-019 SHALL implement states IDLE, REQ, READ, WAIT, WRITE, RELEASE.
REQ-020 IDLE->REQ when any channel is pending: latch the channel's SRC, DST and LEN, clear its pending bit, drive WR_CH, and assert BUSREQ.
REQ-021 REQ: hold BUSREQ=1; on BUSACK=1 go to READ; if the latched LEN=0, go directly to RELEASE with no SRC_CS or WR_EN.
REQ-022 READ (1 cycle): SRC_CS=1, SRC_ADDR=(src+idx) mod 2^AW; then WAIT.
REQ-023 WAIT: RD_LAT cycles counted from READ; sample SRC_DATA on the last one; then WRITE.
REQ-024 WRITE (1 cycle): WR_EN=1, WR_ADDR=(dst+idx) mod 2^AW, WR_DATA=sampled data; idx+1.
REQ-025 Per-word period SHALL be RD_LAT+2 cycles.
REQ-026 After WRITE, go to RELEASE if idx=LEN, else to READ if BUSACK=1, else to REQ with idx held.
REQ-027 A word already in READ/WAIT SHALL complete its WRITE even if BUSACK drops.
REQ-028 RELEASE (1 cycle): BUSREQ=0, pulse DONE[ch]=1, then IDLE; BUSREQ SHALL be low for at least one cycle between channels.
REQ-029 SHALL ignore CH_SRC, CH_DST and CH_LEN changes during an active transfer.
REQ-030 SRC_CS and WR_EN SHALL never be asserted while BUSREQ=0.
REQ-031 BUSY = OR of pending bits, or state != IDLE.

Reset
REQ-032 While RESET96=1 SHALL hold BUSREQ, SRC_CS, WR_EN, BUSY and DONE at 0; SRC_ADDR, WR_ADDR, WR_DATA and WR_CH at 0; state IDLE; pending bits and idx cleared.
REQ-033 Reset mid-transfer SHALL abort the transfer with no further writes, and DONE SHALL NOT pulse.
REQ-034 The TRIG edge detector SHALL reset to "previous=1", so a TRIG held high through reset does not start a transfer.

Verification
REQ-035 Scenario: ch0 SRC=0x0000, DST=0x1000, LEN=4, BUSACK tied 1 -> 4 writes to 0x1000..0x1003 with source data, each 4 cycles apart (RD_LAT=2), then DONE[0] for one cycle.
REQ-036 Scenario: TRIG ch2 and ch1 in the same cycle -> ch1 runs fully; BUSREQ low 1 cycle; then ch2; DONE[1] precedes DONE[2].
REQ-037 Scenario: LEN=3, BUSACK dropped after first WRITE for 5 cycles -> BUSREQ stays 1, no SRC_CS while BUSACK=0, resumes at idx=1, exactly 3 writes.
REQ-038 Scenario: LEN=0 -> BUSREQ asserted until BUSACK, no WR_EN, DONE pulses.
REQ-039 Scenario: SRC=0x3FFE, LEN=4, AW=14 -> reads 0x3FFE, 0x3FFF, 0x0000, 0x0001.
REQ-040 Scenario: RESET96 asserted during the WAIT of word 2 -> all outputs 0 immediately, no DONE; after release, TRIG held high does not restart.
